pipe_alu_gen: RTL and testbench
===============================

Name: pipe_alu_gen

Overview:
- Parametrised, single-clock successor of the team's 4-stage register/ALU/memory pipeline.
- Stages:
  - S1: register read
  - S2: execute
  - S3: register writeback plus output
  - S4: data-memory store
- Adds a valid/ready input handshake, RAW hazard handling, an illegal-opcode flag, and debug read ports so the core can sit behind an instruction sequencer.

Parameters:
- DATA_W, 16, datapath/register/memory word width (>=8)
- REG_AW, 4, register-bank address width (2**REG_AW registers)
- MEM_AW, 8, data-memory address width (2**MEM_AW words)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction present on rs1/rs2/rd/func/addr
- in_ready  output  1  core can accept an instruction this cycle
- rs1  input  REG_AW  source register A
- rs2  input  REG_AW  source register B
- rd  input  REG_AW  destination register
- func  input  4  opcode
- addr  input  MEM_AW  store address; also the immediate for LDI
- zout  output  DATA_W  result of the instruction in S3
- zout_valid  output  1  zout/zout_rd/zout_addr valid
- zout_rd  output  REG_AW  destination of the S3 instruction
- zout_addr  output  MEM_AW  store address of the S3 instruction
- illegal  output  1  S3 instruction had an undefined opcode
- dbg_raddr  input  REG_AW  debug register-read address
- dbg_rdata  output  DATA_W  regbank[dbg_raddr], combinational
- mem_raddr  input  MEM_AW  debug memory-read address
- mem_rdata  output  DATA_W  mem[mem_raddr], combinational

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits, zout, zout_valid, zout_rd, zout_addr and illegal go to 0.
  - All registers go to 0; memory is not reset.
  - In-flight instructions are discarded with no register or memory write.
  - in_ready=0 while rst_n=0.
- Accept: an instruction is accepted on a rising edge with in_valid=1 and in_ready=1. No flow control downstream of S1; the pipeline never back-pressures after accept.
- Latency, for an instruction accepted at edge k:
  - S1 regs at k
  - S2 result at k+1
  - regbank[rd] written and zout/zout_valid presented at k+2; zout_valid is high for exactly one cycle per instruction
  - mem[addr] written at k+3
- Bubbles: cycles without accept propagate as invalid stages; invalid stages write nothing.
- Opcodes (results truncated to DATA_W, two's complement):
  - 0 A+B, 1 A-B, 2 A*B (low DATA_W bits), 3 A, 4 B, 5 A&B, 6 A|B, 7 A^B
  - 8 -A, 9 -B, 10 A>>1 logical, 11 A<<1, 12 LDI: zero-extended addr
- Undefined opcodes (13-15):
  - Result 0, illegal=1 in S3.
  - Register and memory writes still occur with value 0.
- Operand sourcing at S1 capture, for each of rs1/rs2, youngest match wins:
  1. S1 instruction valid and rd matches: S2 combinational result.
  2. Else S2 instruction valid and rd matches: S2 registered result, being written this edge.
  3. Else regbank.
- This ordering also covers the same-edge write/read case.
- Two S3 writes to the same rd: in-order, last wins.
- Memory write: single port. A store and a debug read of the same address return the old value until the edge.

Optional Feature:
- PIPE_FWD_EN defined: operand forwarding as above; in_ready=1 whenever out of reset, so back-to-back dependent instructions issue at one per cycle.
- PIPE_FWD_EN undefined:
  - No forwarding; operands always come from regbank.
  - in_ready=0 while rs1 or rs2 of the presented instruction matches rd of a valid S1 or S2 instruction (the check applies regardless of in_valid). An immediately dependent instruction therefore stalls 2 cycles.
  - Results must be identical to the forwarding build; only timing differs.

Test Plan:
- Reset mid-stream: issue LDI r1=0x0AA, assert rst_n=0 one cycle later -> zout_valid never rises, dbg_rdata(r1)=0, mem[0x0AA] unchanged.
- LDI r1=5, LDI r2=3, then ADD r3=r1+r2 back-to-back:
  - With PIPE_FWD_EN: no stall, zout=8 two edges after ADD accept, dbg_rdata(r3)=8.
  - Without PIPE_FWD_EN: in_ready low 2 cycles before ADD accepts, zout=8.
- All 16 opcodes with A=0x8001, B=0x0003 (DATA_W=16) -> expected results, e.g.:
  - SUB 0x7FFE, MUL 0x8003, NEG A 0x7FFF, SHR 0x4000, SHL 0x0002
  - funcs 13-15 give zout=0, illegal=1.
- Store: ADD rd=r4 addr=0x3C -> mem[0x3C] equals zout exactly one edge after zout_valid.
- Back-to-back writes to r5 (LDI 1, LDI 2), then ADD r6=r5+r5 -> zout=4, proving youngest-wins forwarding.
- DATA_W=32, REG_AW=5, MEM_AW=10 build: LDI r31=0x3FF, SHL r31 four times chained -> 0x3FF0, mem[addr] correct.

Source files
------------

// File: rtl/pipe_alu_gen.sv
// pipe_alu_gen: 4-stage register-read / execute / writeback / store pipeline with valid/ready issue.
// Build option: define PIPE_FWD_EN for operand forwarding; otherwise RAW hazards stall issue.
module pipe_alu_gen #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [3:0]        func,
  input  logic [MEM_AW-1:0] addr,
  output logic [DATA_W-1:0] zout,
  output logic              zout_valid,
  output logic [REG_AW-1:0] zout_rd,
  output logic [MEM_AW-1:0] zout_addr,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic [MEM_AW-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int NREG = 1 << REG_AW;
  localparam int NMEM = 1 << MEM_AW;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_PASSA = 4'd3,
    OP_PASSB = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_NEGA  = 4'd8,
    OP_NEGB  = 4'd9,
    OP_SHR   = 4'd10,
    OP_SHL   = 4'd11,
    OP_LDI   = 4'd12
  } op_e;

  logic [DATA_W-1:0] regbank_q [NREG];
  logic [DATA_W-1:0] mem_q     [NMEM];

  // S1: captured operands and control
  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic [DATA_W-1:0] s1_a_d, s1_b_d;
  logic [REG_AW-1:0] s1_rd_q;
  logic [3:0]        s1_func_q;
  logic [MEM_AW-1:0] s1_addr_q;

  // S2: registered execute result
  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_res_q, s2_res_d;
  logic              s2_illegal_q, s2_illegal_d;
  logic [REG_AW-1:0] s2_rd_q;
  logic [MEM_AW-1:0] s2_addr_q;

  // S3: output registers, also the source of the S4 store
  logic              zout_valid_q;
  logic [DATA_W-1:0] zout_q;
  logic [REG_AW-1:0] zout_rd_q;
  logic [MEM_AW-1:0] zout_addr_q;
  logic              illegal_q;

  logic hazard;
  logic accept;

`ifdef PIPE_FWD_EN
  assign hazard = 1'b0;
`else
  assign hazard = (s1_valid_q && (s1_rd_q == rs1 || s1_rd_q == rs2)) ||
                  (s2_valid_q && (s2_rd_q == rs1 || s2_rd_q == rs2));
`endif

  assign in_ready = rst_n & ~hazard;
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    s2_res_d     = '0;
    s2_illegal_d = 1'b0;
    case (s1_func_q)
      OP_ADD:   s2_res_d = s1_a_q + s1_b_q;
      OP_SUB:   s2_res_d = s1_a_q - s1_b_q;
      OP_MUL:   s2_res_d = s1_a_q * s1_b_q;
      OP_PASSA: s2_res_d = s1_a_q;
      OP_PASSB: s2_res_d = s1_b_q;
      OP_AND:   s2_res_d = s1_a_q & s1_b_q;
      OP_OR:    s2_res_d = s1_a_q | s1_b_q;
      OP_XOR:   s2_res_d = s1_a_q ^ s1_b_q;
      OP_NEGA:  s2_res_d = '0 - s1_a_q;
      OP_NEGB:  s2_res_d = '0 - s1_b_q;
      OP_SHR:   s2_res_d = s1_a_q >> 1;
      OP_SHL:   s2_res_d = s1_a_q << 1;
      OP_LDI:   s2_res_d = DATA_W'(s1_addr_q);
      default:  s2_illegal_d = 1'b1;
    endcase
  end

  // Later assignments override earlier ones, so the youngest in-flight producer wins.
  always_comb begin
    s1_a_d = regbank_q[rs1];
    s1_b_d = regbank_q[rs2];
`ifdef PIPE_FWD_EN
    if (s2_valid_q && s2_rd_q == rs1) s1_a_d = s2_res_q;
    if (s2_valid_q && s2_rd_q == rs2) s1_b_d = s2_res_q;
    if (s1_valid_q && s1_rd_q == rs1) s1_a_d = s2_res_d;
    if (s1_valid_q && s1_rd_q == rs2) s1_b_d = s2_res_d;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_rd_q      <= '0;
      s1_func_q    <= '0;
      s1_addr_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_res_q     <= '0;
      s2_illegal_q <= 1'b0;
      s2_rd_q      <= '0;
      s2_addr_q    <= '0;
      zout_valid_q <= 1'b0;
      zout_q       <= '0;
      zout_rd_q    <= '0;
      zout_addr_q  <= '0;
      illegal_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regbank_q[i] <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q    <= s1_a_d;
        s1_b_q    <= s1_b_d;
        s1_rd_q   <= rd;
        s1_func_q <= func;
        s1_addr_q <= addr;
      end

      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_res_q     <= s2_res_d;
        s2_illegal_q <= s2_illegal_d;
        s2_rd_q      <= s1_rd_q;
        s2_addr_q    <= s1_addr_q;
      end

      zout_valid_q <= s2_valid_q;
      illegal_q    <= s2_valid_q & s2_illegal_q;
      if (s2_valid_q) begin
        zout_q               <= s2_res_q;
        zout_rd_q            <= s2_rd_q;
        zout_addr_q          <= s2_addr_q;
        regbank_q[s2_rd_q]   <= s2_res_q;
      end
    end
  end

  // NOTE: the data memory has no reset; it is plain storage and clearing it would cost a write port per word.
  always_ff @(posedge clk) begin
    if (zout_valid_q) mem_q[zout_addr_q] <= zout_q;
  end

  assign zout       = zout_q;
  assign zout_valid = zout_valid_q;
  assign zout_rd    = zout_rd_q;
  assign zout_addr  = zout_addr_q;
  assign illegal    = illegal_q;
  assign dbg_rdata  = regbank_q[dbg_raddr];
  assign mem_rdata  = mem_q[mem_raddr];

endmodule

// File: tb/tb_pipe_alu_gen.sv
// Bench for pipe_alu_gen: directed programs checked each cycle against an in-order ISA model.
module tb_pipe_alu_gen;

  localparam int DW  = 16;
  localparam int RAW = 4;
  localparam int MAW = 8;
  localparam longint MASK = (64'd1 << DW) - 1;
`ifdef PIPE_FWD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 2;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [RAW-1:0] rs1, rs2, rd;
  logic [3:0]     func;
  logic [MAW-1:0] addr;
  logic [DW-1:0]  zout;
  logic           zout_valid;
  logic [RAW-1:0] zout_rd;
  logic [MAW-1:0] zout_addr;
  logic           illegal;
  logic [RAW-1:0] dbg_raddr;
  logic [DW-1:0]  dbg_rdata;
  logic [MAW-1:0] mem_raddr;
  logic [DW-1:0]  mem_rdata;

  pipe_alu_gen #(.DATA_W(DW), .REG_AW(RAW), .MEM_AW(MAW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .zout(zout), .zout_valid(zout_valid), .zout_rd(zout_rd), .zout_addr(zout_addr),
    .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // In-order architectural model: results are computed at issue from the model register file.
  typedef struct {
    int          due;
    longint      res;
    int          rd;
    int          addr;
    bit          ill;
    bit          has_lit;
    logic [63:0] lit;
  } exp_t;

  exp_t        q[$];
  longint      mregs[1 << RAW];
  int          cyc = 0;
  bit          has_lit_in = 1'b0;
  logic [63:0] lit_in = '0;

  logic [63:0] lits [16] = '{64'h8004, 64'h7FFE, 64'h8003, 64'h8001, 64'h0003, 64'h0001,
                             64'h8003, 64'h8002, 64'h7FFF, 64'hFFFD, 64'h4000, 64'h0002,
                             64'h004C, 64'h0000, 64'h0000, 64'h0000};

  function automatic longint alu(input int f, input longint a, input longint b, input longint im);
    case (f)
      0:  return (a + b) & MASK;
      1:  return (a - b) & MASK;
      2:  return (a * b) & MASK;
      3:  return a;
      4:  return b;
      5:  return a & b;
      6:  return a | b;
      7:  return a ^ b;
      8:  return (-a) & MASK;
      9:  return (-b) & MASK;
      10: return a >> 1;
      11: return (a << 1) & MASK;
      12: return im & MASK;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin : compare
    exp_t e;
    bit   rdy;
    cyc++;
    if (!rst_n) begin
      check("rst_in_ready", in_ready, 0);
      check("rst_zout_valid", zout_valid, 0);
      check("rst_zout", zout, 0);
      check("rst_zout_rd", zout_rd, 0);
      check("rst_zout_addr", zout_addr, 0);
      check("rst_illegal", illegal, 0);
      q.delete();
      foreach (mregs[i]) mregs[i] = 0;
    end else begin
      rdy = 1'b1;
`ifndef PIPE_FWD_EN
      // Producers accepted on the last two edges have not reached the register bank yet.
      foreach (q[i])
        if ((q[i].due == cyc + 1 || q[i].due == cyc + 2) &&
            (q[i].rd == int'(rs1) || q[i].rd == int'(rs2))) rdy = 1'b0;
`endif
      check("in_ready", in_ready, rdy);
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("zout_valid", zout_valid, 1);
        check("zout", zout, e.res);
        check("zout_rd", zout_rd, e.rd);
        check("zout_addr", zout_addr, e.addr);
        check("illegal", illegal, e.ill);
        if (e.has_lit) check("zout_literal", zout, e.lit);
      end else begin
        check("zout_valid_idle", zout_valid, 0);
      end
      if (in_valid && in_ready) begin
        e.due     = cyc + 3;
        e.res     = alu(int'(func), mregs[rs1], mregs[rs2], longint'(addr));
        e.rd      = int'(rd);
        e.addr    = int'(addr);
        e.ill     = (func >= 4'd13);
        e.has_lit = has_lit_in;
        e.lit     = lit_in;
        mregs[rd] = e.res;
        q.push_back(e);
      end
    end
  end

  // Called and returns at posedge+2; keeps in_valid high until the accepting edge.
  task automatic issue(input int f, input int d, input int a, input int b, input int ad,
                       input bit hl, input logic [63:0] lit, output int stalls);
    func = 4'(f); rd = RAW'(d); rs1 = RAW'(a); rs2 = RAW'(b); addr = MAW'(ad);
    has_lit_in = hl; lit_in = lit; in_valid = 1'b1; stalls = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 20) begin
        check("issue_stall_bound", in_ready, 1);
        break;
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0; has_lit_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic rd_reg(input int r, input logic [63:0] exp, input string name);
    dbg_raddr = RAW'(r); #1;
    check(name, dbg_rdata, exp);
    idle(1);
  endtask

  task automatic rd_mem(input int a, input logic [63:0] exp, input string name);
    mem_raddr = MAW'(a); #1;
    check(name, mem_rdata, exp);
    idle(1);
  endtask

  initial begin : stim
    int st;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0;
    dbg_raddr = '0; mem_raddr = '0;
    repeat (3) @(posedge clk); #2;
    rd_reg(3, 0, "rst_reg3");
    rst_n = 1'b1;

    // Seed known memory contents (r0 is 0 after reset).
    issue(3, 9, 0, 0, 'hAA, 1, 0, st);
    issue(3, 9, 0, 0, 'h3C, 1, 0, st);
    idle(6);
    rd_mem('hAA, 0, "seed_mem_aa");

    // Reset while LDI r1=0xAA is in flight: nothing may be written or presented.
    issue(12, 1, 0, 0, 'hAA, 0, 0, st);
    @(posedge clk); #2;
    rst_n = 1'b0;
    idle(2);
    rd_reg(1, 0, "rst_mid_r1_in_reset");
    rst_n = 1'b1;
    idle(5);
    rd_reg(1, 0, "rst_mid_r1");
    rd_mem('hAA, 0, "rst_mid_mem_aa");

    // Dependent ADD directly behind its producers.
    issue(12, 1, 0, 0, 5, 1, 5, st);
    issue(12, 2, 0, 0, 3, 1, 3, st);
    issue(0, 3, 1, 2, 'h10, 1, 8, st);
    check("add_stall_cycles", st, EXP_STALL);
    idle(4);
    rd_reg(3, 8, "dbg_r3");

    // Build A=0x8001 in r7 and B=3 in r8, then sweep every opcode.
    issue(12, 7, 0, 0, 'h80, 1, 'h80, st);
    issue(2, 7, 7, 7, 0, 1, 'h4000, st);
    issue(0, 7, 7, 7, 0, 1, 'h8000, st);
    issue(12, 10, 0, 0, 1, 1, 1, st);
    issue(6, 7, 7, 10, 0, 1, 'h8001, st);
    issue(12, 8, 0, 0, 3, 1, 3, st);
    for (int f = 0; f < 16; f++) issue(f, 11, 7, 8, 'h40 + f, 1, lits[f], st);
    idle(5);
    rd_reg(7, 'h8001, "dbg_r7");
    rd_reg(11, 0, "dbg_r11_after_illegal");
    rd_mem('h41, 'h7FFE, "mem_sub");
    rd_mem('h4C, 'h4C, "mem_ldi");
    rd_mem('h4F, 0, "mem_illegal_store");

    // Store lands exactly one edge after zout_valid; the old value is visible until then.
    issue(0, 4, 1, 2, 'h3C, 1, 8, st);
    mem_raddr = 'h3C;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!zout_valid && n < 10);
    check("store_zout_valid", zout_valid, 1);
    check("store_mem_before", mem_rdata, 0);
    @(negedge clk);
    check("store_mem_after", mem_rdata, 8);
    @(posedge clk); #2;

    // Two writes to r5 back to back; the consumer must see the younger one.
    issue(12, 5, 0, 0, 1, 1, 1, st);
    issue(12, 5, 0, 0, 2, 1, 2, st);
    issue(0, 6, 5, 5, 'h20, 1, 4, st);
    idle(5);
    rd_reg(6, 4, "dbg_r6");
    rd_reg(5, 2, "dbg_r5");

    // Chained shifts on one register.
    issue(12, 14, 0, 0, 'hFF, 1, 'hFF, st);
    issue(11, 14, 14, 0, 'h70, 1, 'h1FE, st);
    issue(11, 14, 14, 0, 'h71, 1, 'h3FC, st);
    issue(11, 14, 14, 0, 'h72, 1, 'h7F8, st);
    issue(11, 14, 14, 0, 'h77, 1, 'hFF0, st);
    idle(5);
    rd_mem('h77, 'hFF0, "mem_shl_chain");
    rd_reg(14, 'hFF0, "dbg_r14");

    idle(2);
    check("model_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: got time %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
